// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: req/ack data-memory bus between dmem_bridge and its slave.
// Requests are held until a single-cycle ack arrives or the bridge aborts them.
interface dmem_bridge_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: runs datapath loads/stores on a variable-latency req/ack bus.
// Optional one-entry posted-write buffer under `define DMEM_WBUF_EN.
module dmem_bridge #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             Stall,
    output logic             BusErr,
    dmem_bridge_if.master    bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

`ifdef DMEM_WBUF_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, WPOST} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             we_q;
    logic             req_q;
    logic             berr_q;
    logic [CW-1:0]    cnt;

    logic access;
    logic aligned;
    logic expire;
    logic stall_c;

    assign access  = MemRead | MemWrite;
    assign aligned = (ALUResult[1:0] == 2'b00);
    // Ack in the last allowed cycle still completes normally.
    assign expire  = req_q & ~bus.mem_ack & (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            berr_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            berr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (access && aligned) begin
                        addr_q  <= {ALUResult[WIDTH-1:2], 2'b00};
                        wdata_q <= WriteData;
                        we_q    <= MemWrite;
                        req_q   <= 1'b1;
                        cnt     <= '0;
`ifdef DMEM_WBUF_EN
                        state   <= MemWrite ? WPOST : REQ;
`else
                        state   <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (!we_q) rdata_q <= bus.mem_rdata;
                        req_q <= 1'b0;
                        cnt   <= '0;
                        state <= DONE;
                    end else if (expire) begin
                        rdata_q <= '0;
                        berr_q  <= 1'b1;
                        req_q   <= 1'b0;
                        cnt     <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef DMEM_WBUF_EN
                WPOST: begin
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (expire) begin
                        berr_q <= 1'b1;
                        req_q  <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_c = 1'b0;
        unique case (state)
`ifdef DMEM_WBUF_EN
            IDLE:  stall_c = access & aligned & ~MemWrite;
            WPOST: stall_c = access;
`else
            IDLE:  stall_c = access & aligned;
`endif
            REQ:   stall_c = 1'b1;
            DONE:  stall_c = 1'b0;
            default: stall_c = 1'b0;
        endcase
    end

    // Gated with reset so the core sees no stall or error while held in reset.
    assign Stall    = reset & stall_c;
    assign BusErr   = reset & (berr_q | ((state == IDLE) & access & ~aligned));
    assign ReadData = (state == DONE) ? rdata_q : '0;

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = req_q & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: scoreboard bench for dmem_bridge.
// Expected bus cycles/results are queued at stimulus time and popped at completion.
module tb_dmem_bridge;

    localparam int W  = 32;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         MemRead = 1'b0;
    logic         MemWrite = 1'b0;
    logic [W-1:0] ALUResult = '0;
    logic [W-1:0] WriteData = '0;
    logic [W-1:0] ReadData;
    logic         Stall;
    logic         BusErr;

    dmem_bridge_if #(.WIDTH(W)) bus ();

    dmem_bridge #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Stall(Stall),
        .BusErr(BusErr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           vecs = 0;
    int           errs = 0;
    logic [W-1:0] rdq_model = '0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one aligned access to completion; records observations only.
    task automatic run_access(
        input  logic rd, input logic wr,
        input  logic [W-1:0] addr, input logic [W-1:0] wdata,
        input  int ack_at, input logic [W-1:0] rdata,
        output int stalls, output int reqs,
        output logic [W-1:0] rd_out, output logic err_out,
        output logic stable, output logic b_we,
        output logic [W-1:0] b_addr, output logic [W-1:0] b_wdata,
        output logic finished
    );
        stalls = 0; reqs = 0; rd_out = '0; err_out = 1'b0;
        stable = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        finished = 1'b0;
        MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wdata;
        for (int c = 0; c < 64 && !finished; c++) begin
            bus.mem_ack   = bus.mem_req && (reqs == ack_at);
            bus.mem_rdata = bus.mem_ack ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (Stall) stalls++;
            if (bus.mem_req) begin
                if (reqs == 0) begin
                    b_we = bus.mem_we; b_addr = bus.mem_addr; b_wdata = bus.mem_wdata;
                end else if (bus.mem_we !== b_we || bus.mem_addr !== b_addr || bus.mem_wdata !== b_wdata) begin
                    stable = 1'b0;
                end
                reqs++;
            end else if (reqs > 0) begin
                rd_out = ReadData; err_out = BusErr; finished = 1'b1;
            end
            step();
        end
        bus.mem_ack = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; MemRead = 1'b1; ALUResult = 32'h40;
        @(negedge clk);
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b want=0", Stall); end
        vecs++; if (BusErr !== 1'b0) begin errs++; $display("FAIL reset_buserr got=%b want=0", BusErr); end
        vecs++; if (bus.mem_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b want=0", bus.mem_req); end
        vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL reset_rdata got=%h want=0", ReadData); end
        vecs++; if (bus.mem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got=%h want=0", bus.mem_addr); end
        step();
        MemRead = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_midreq;
        MemRead = 1'b1; ALUResult = 32'h100;
        @(negedge clk);
        vecs++; if (Stall !== 1'b1) begin errs++; $display("FAIL midrst_idle_stall got=%b want=1", Stall); end
        step();
        step();
        vecs++; if (bus.mem_req !== 1'b1) begin errs++; $display("FAIL midrst_req_before got=%b want=1", bus.mem_req); end
        #2 reset = 1'b0;
        #1;
        vecs++; if (bus.mem_req !== 1'b0) begin errs++; $display("FAIL midrst_req_drop got=%b want=0", bus.mem_req); end
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL midrst_stall_drop got=%b want=0", Stall); end
        step();
        MemRead = 1'b0;
        reset = 1'b1;
        rdq_model = '0;
        step();
        @(negedge clk);
        vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL midrst_rdata got=%h want=0", ReadData); end
        vecs++; if (Stall !== 1'b0 || bus.mem_req !== 1'b0) begin errs++; $display("FAIL midrst_idle got stall=%b req=%b want 0/0", Stall, bus.mem_req); end
        step();
    endtask

    task automatic test_load;
        int st, rq; logic [W-1:0] rdo, ba, bw; logic er, stb, bwe, fin;
        exp_t e;
        sb.push_back('{1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0});
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hCAFE_F00D, st, rq, rdo, er, stb, bwe, ba, bw, fin);
        e = sb.pop_front();
        rdq_model = e.rdata;
        vecs++; if (fin !== 1'b1) begin errs++; $display("FAIL load_timeout got=%b want=1", fin); end
        vecs++; if (st != 5) begin errs++; $display("FAIL load_stalls got=%0d want=5", st); end
        vecs++; if (rq != 4) begin errs++; $display("FAIL load_reqs got=%0d want=4", rq); end
        vecs++; if (stb !== 1'b1) begin errs++; $display("FAIL load_stable got=%b want=1", stb); end
        vecs++; if (bwe !== e.we || ba !== e.addr) begin errs++; $display("FAIL load_bus got we=%b addr=%h want we=%b addr=%h", bwe, ba, e.we, e.addr); end
        vecs++; if (rdo !== e.rdata) begin errs++; $display("FAIL load_rdata got=%h want=%h", rdo, e.rdata); end
        vecs++; if (er !== e.err) begin errs++; $display("FAIL load_err got=%b want=%b", er, e.err); end
    endtask

    task automatic test_store;
`ifdef DMEM_WBUF_EN
        exp_t e;
        sb.push_back('{1'b1, 32'h80, 32'h1234_5678, rdq_model, 1'b0});
        MemWrite = 1'b1; ALUResult = 32'h80; WriteData = 32'h1234_5678;
        @(negedge clk);
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL pstore_stall got=%b want=0", Stall); end
        step();
        MemWrite = 1'b0;
        bus.mem_ack = bus.mem_req;
        @(negedge clk);
        e = sb.pop_front();
        vecs++; if (bus.mem_req !== 1'b1) begin errs++; $display("FAIL pstore_req got=%b want=1", bus.mem_req); end
        vecs++; if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || bus.mem_wdata !== e.wdata) begin errs++; $display("FAIL pstore_bus got we=%b addr=%h data=%h want we=%b addr=%h data=%h", bus.mem_we, bus.mem_addr, bus.mem_wdata, e.we, e.addr, e.wdata); end
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vecs++; if (bus.mem_req !== 1'b0 || BusErr !== 1'b0) begin errs++; $display("FAIL pstore_end got req=%b err=%b want 0/0", bus.mem_req, BusErr); end
        step();
`else
        int st, rq; logic [W-1:0] rdo, ba, bw; logic er, stb, bwe, fin;
        exp_t e;
        sb.push_back('{1'b1, 32'h80, 32'h1234_5678, rdq_model, 1'b0});
        run_access(1'b0, 1'b1, 32'h80, 32'h1234_5678, 0, 32'h0, st, rq, rdo, er, stb, bwe, ba, bw, fin);
        e = sb.pop_front();
        vecs++; if (fin !== 1'b1) begin errs++; $display("FAIL store_timeout got=%b want=1", fin); end
        vecs++; if (st != 2) begin errs++; $display("FAIL store_stalls got=%0d want=2", st); end
        vecs++; if (bwe !== e.we || ba !== e.addr || bw !== e.wdata) begin errs++; $display("FAIL store_bus got we=%b addr=%h data=%h want we=%b addr=%h data=%h", bwe, ba, bw, e.we, e.addr, e.wdata); end
        vecs++; if (er !== e.err) begin errs++; $display("FAIL store_err got=%b want=%b", er, e.err); end
        vecs++; if (rdo !== e.rdata) begin errs++; $display("FAIL store_rdq_kept got=%h want=%h", rdo, e.rdata); end
        // Read and write together behave as a store.
        sb.push_back('{1'b1, 32'h84, 32'h0BAD_0084, rdq_model, 1'b0});
        run_access(1'b1, 1'b1, 32'h84, 32'h0BAD_0084, 1, 32'h7777_7777, st, rq, rdo, er, stb, bwe, ba, bw, fin);
        e = sb.pop_front();
        vecs++; if (bwe !== e.we || ba !== e.addr || bw !== e.wdata) begin errs++; $display("FAIL both_bus got we=%b addr=%h data=%h want we=%b addr=%h data=%h", bwe, ba, bw, e.we, e.addr, e.wdata); end
        vecs++; if (rdo !== e.rdata) begin errs++; $display("FAIL both_rdata got=%h want=%h", rdo, e.rdata); end
`endif
    endtask

    task automatic test_misaligned;
        logic [W-1:0] addrs [3];
        logic         wrs [3];
        addrs[0] = 32'h42; addrs[1] = 32'h81; addrs[2] = 32'h43;
        wrs[0] = 1'b0; wrs[1] = 1'b1; wrs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemRead = ~wrs[i]; MemWrite = wrs[i]; ALUResult = addrs[i]; WriteData = 32'h5555_AAAA;
            @(negedge clk);
            vecs++; if (BusErr !== 1'b1) begin errs++; $display("FAIL mis_err[%0d] got=%b want=1", i, BusErr); end
            vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL mis_stall[%0d] got=%b want=0", i, Stall); end
            vecs++; if (bus.mem_req !== 1'b0) begin errs++; $display("FAIL mis_req[%0d] got=%b want=0", i, bus.mem_req); end
            vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL mis_rdata[%0d] got=%h want=0", i, ReadData); end
            step();
            MemRead = 1'b0; MemWrite = 1'b0;
            @(negedge clk);
            vecs++; if (BusErr !== 1'b0 || bus.mem_req !== 1'b0) begin errs++; $display("FAIL mis_after[%0d] got err=%b req=%b want 0/0", i, BusErr, bus.mem_req); end
            step();
        end
    endtask

    task automatic test_timeout;
        int st, rq; logic [W-1:0] rdo, ba, bw; logic er, stb, bwe, fin;
        exp_t e;
        sb.push_back('{1'b0, 32'h200, 32'h0, 32'h0, 1'b1});
        run_access(1'b1, 1'b0, 32'h200, 32'h0, -1, 32'h0, st, rq, rdo, er, stb, bwe, ba, bw, fin);
        e = sb.pop_front();
        rdq_model = e.rdata;
        vecs++; if (rq != TO) begin errs++; $display("FAIL to_reqs got=%0d want=%0d", rq, TO); end
        vecs++; if (st != TO + 1) begin errs++; $display("FAIL to_stalls got=%0d want=%0d", st, TO + 1); end
        vecs++; if (er !== e.err) begin errs++; $display("FAIL to_err got=%b want=%b", er, e.err); end
        vecs++; if (rdo !== e.rdata) begin errs++; $display("FAIL to_rdata got=%h want=%h", rdo, e.rdata); end
        vecs++; if (ba !== e.addr) begin errs++; $display("FAIL to_addr got=%h want=%h", ba, e.addr); end
        @(negedge clk);
        vecs++; if (BusErr !== 1'b0 || Stall !== 1'b0 || bus.mem_req !== 1'b0) begin errs++; $display("FAIL to_idle got err=%b stall=%b req=%b want 0/0/0", BusErr, Stall, bus.mem_req); end
        step();
        // Ack in the final allowed cycle wins over the abort.
        sb.push_back('{1'b0, 32'h204, 32'h0, 32'h5A5A_A5A5, 1'b0});
        run_access(1'b1, 1'b0, 32'h204, 32'h0, TO - 1, 32'h5A5A_A5A5, st, rq, rdo, er, stb, bwe, ba, bw, fin);
        e = sb.pop_front();
        rdq_model = e.rdata;
        vecs++; if (rq != TO) begin errs++; $display("FAIL edge_reqs got=%0d want=%0d", rq, TO); end
        vecs++; if (er !== e.err) begin errs++; $display("FAIL edge_err got=%b want=%b", er, e.err); end
        vecs++; if (rdo !== e.rdata) begin errs++; $display("FAIL edge_rdata got=%h want=%h", rdo, e.rdata); end
    endtask

    task automatic test_ack_ignored;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        vecs++; if (bus.mem_req !== 1'b0 || Stall !== 1'b0) begin errs++; $display("FAIL stray_ack got req=%b stall=%b want 0/0", bus.mem_req, Stall); end
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL stray_rdata got=%h want=0", ReadData); end
        step();
    endtask

    task automatic test_back_to_back;
        int st, rq; logic [W-1:0] rdo, ba, bw; logic er, stb, bwe, fin;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{1'b0, 32'h400 + 32'(4 * i), 32'h0, 32'h1111_0000 + 32'(i), 1'b0});
            run_access(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h0, i, 32'h1111_0000 + 32'(i), st, rq, rdo, er, stb, bwe, ba, bw, fin);
            e = sb.pop_front();
            rdq_model = e.rdata;
            vecs++; if (st != i + 2) begin errs++; $display("FAIL b2b_stalls[%0d] got=%0d want=%0d", i, st, i + 2); end
            vecs++; if (ba !== e.addr || bwe !== e.we) begin errs++; $display("FAIL b2b_bus[%0d] got addr=%h we=%b want addr=%h we=%b", i, ba, bwe, e.addr, e.we); end
            vecs++; if (rdo !== e.rdata) begin errs++; $display("FAIL b2b_rdata[%0d] got=%h want=%h", i, rdo, e.rdata); end
        end
    endtask

`ifdef DMEM_WBUF_EN
    task automatic test_wbuf;
        exp_t e;
        logic [W-1:0] rd_exp = '0;
        int rcnt = 0;
        int seen = 0;
        logic fin = 1'b0;
        sb.push_back('{1'b1, 32'h300, 32'hA5A5_0300, 32'h0, 1'b0});
        sb.push_back('{1'b0, 32'h304, 32'h0, 32'h0304_BEEF, 1'b0});
        MemWrite = 1'b1; ALUResult = 32'h300; WriteData = 32'hA5A5_0300;
        @(negedge clk);
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL wbuf_store_stall got=%b want=0", Stall); end
        step();
        MemWrite = 1'b0; MemRead = 1'b1; ALUResult = 32'h304; WriteData = 32'h0;
        for (int c = 0; c < 40 && !fin; c++) begin
            bus.mem_ack   = bus.mem_req && (rcnt == 2);
            bus.mem_rdata = bus.mem_ack ? 32'h0304_BEEF : 32'hDEAD_BEEF;
            @(negedge clk);
            if (bus.mem_req) begin
                vecs++; if (Stall !== 1'b1) begin errs++; $display("FAIL wbuf_bus_stall[%0d] got=%b want=1", c, Stall); end
                if (bus.mem_ack) begin
                    e = sb.pop_front();
                    rd_exp = e.rdata;
                    seen++;
                    vecs++; if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || (e.we && bus.mem_wdata !== e.wdata)) begin errs++; $display("FAIL wbuf_order[%0d] got we=%b addr=%h want we=%b addr=%h", seen, bus.mem_we, bus.mem_addr, e.we, e.addr); end
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else if (seen == 2) begin
                vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL wbuf_done_stall got=%b want=0", Stall); end
                vecs++; if (ReadData !== rd_exp) begin errs++; $display("FAIL wbuf_rdata got=%h want=%h", ReadData, rd_exp); end
                fin = 1'b1;
            end else begin
                vecs++; if (Stall !== 1'b1) begin errs++; $display("FAIL wbuf_idle_stall[%0d] got=%b want=1", c, Stall); end
            end
            step();
        end
        bus.mem_ack = 1'b0;
        MemRead = 1'b0;
        rdq_model = rd_exp;
        vecs++; if (fin !== 1'b1) begin errs++; $display("FAIL wbuf_timeout got=%b want=1", fin); end
    endtask
`endif

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #1;
        test_reset();
        test_reset_midreq();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_ignored();
        test_back_to_back();
`ifdef DMEM_WBUF_EN
        test_wbuf();
`endif
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=expired want=finished");
        $fatal(1, "watchdog");
    end

endmodule
